// File: rtl/ann_stream_loader.sv
// Byte-stream front end for the weight_layers ANN core: decodes weight frames into per-row
// train writes and input frames into an inference launch, then holds the one-hot result.
module ann_stream_loader #(
  parameter int unsigned layers                = 2,
  parameter int unsigned datawidth             = 8,
  parameter int unsigned rows [layers]         = '{2, 2},
  parameter int unsigned cols [layers]         = '{3, 2},
  parameter int unsigned max_rows              = 2,
  parameter int unsigned max_cols              = 3,
  parameter int unsigned timeout_cycles        = 1023,
  localparam int unsigned LayerW = (layers > 1) ? $clog2(layers) : 1,
  localparam int unsigned RowW   = (max_rows > 1) ? $clog2(max_rows) : 1,
  localparam int unsigned ColW   = (max_cols > 1) ? $clog2(max_cols) : 1,
  localparam int unsigned WaitW  = $clog2(timeout_cycles + 1)
) (
  input  logic                            clk,
  input  logic                            rst_overall_n,
  input  logic [datawidth-1:0]            s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic                            rst_vals,
  output logic                            train,
  output logic [LayerW-1:0]               train_layer_select,
  output logic [RowW-1:0]                 row_sel,
  output logic [max_cols*datawidth-1:0]   weight_update,
  output logic [max_rows*2*datawidth-1:0] bias_updates,
  output logic [cols[0]*datawidth-1:0]    input_values,
  output logic                            en,
  output logic                            input_loaded,
  input  logic                            core_final_done,
  input  logic [rows[layers-1]-1:0]       core_final_out,
  output logic [rows[layers-1]-1:0]       result_onehot,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic                            err
);

  typedef enum logic [2:0] {
    StIdle, StWCollect, StWWrite, StICollect, StLaunch, StWaitDone, StResult
  } state_e;

  state_e                state_q;
  logic [LayerW-1:0]     layer_q;
  logic [RowW-1:0]       row_q;
  logic [ColW-1:0]       col_q;
  logic [WaitW-1:0]      wait_q;
  logic [datawidth-1:0]  row_buf_q [max_cols];
  logic [max_cols*datawidth-1:0] row_word;
  logic                  accept;
  logic                  last_col, last_row, last_layer, last_input;

  assign s_ready      = (state_q == StIdle) || (state_q == StWCollect) || (state_q == StICollect);
  assign accept       = s_valid && s_ready;
  assign bias_updates = '0;

  assign last_col   = (col_q == ColW'(cols[layer_q] - 1));
  assign last_row   = (row_q == RowW'(rows[layer_q] - 1));
  assign last_layer = (layer_q == LayerW'(layers - 1));
  assign last_input = (col_q == ColW'(cols[0] - 1));

  // Completed row including the byte being accepted now; columns beyond this layer stay zero.
  always_comb begin
    row_word = '0;
    for (int c = 0; c < int'(max_cols); c++) begin
      if (c < int'(cols[layer_q])) begin
        row_word[c*datawidth +: datawidth] = (ColW'(c) == col_q) ? s_data : row_buf_q[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_overall_n) begin
    if (!rst_overall_n) begin
      state_q            <= StIdle;
      layer_q            <= '0;
      row_q              <= '0;
      col_q              <= '0;
      wait_q             <= '0;
      for (int c = 0; c < int'(max_cols); c++) row_buf_q[c] <= '0;
      rst_vals           <= 1'b0;
      train              <= 1'b0;
      train_layer_select <= '0;
      row_sel            <= '0;
      weight_update      <= '0;
      input_values       <= '0;
      en                 <= 1'b0;
      input_loaded       <= 1'b0;
      result_onehot      <= '0;
      result_valid       <= 1'b0;
      err                <= 1'b0;
    end else begin
      rst_vals     <= 1'b0;
      train        <= 1'b0;
      en           <= 1'b0;
      input_loaded <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (s_data == datawidth'(1)) begin
              rst_vals <= 1'b1;
              layer_q  <= '0;
              row_q    <= '0;
              col_q    <= '0;
              for (int c = 0; c < int'(max_cols); c++) row_buf_q[c] <= '0;
              state_q  <= StWCollect;
            end else if (s_data == datawidth'(2)) begin
              col_q   <= '0;
              state_q <= StICollect;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StWCollect: begin
          if (accept) begin
            row_buf_q[col_q] <= s_data;
            if (last_col) begin
              train              <= 1'b1;
              train_layer_select <= layer_q;
              row_sel            <= row_q;
              weight_update      <= row_word;
              state_q            <= StWWrite;
            end else begin
              col_q <= col_q + ColW'(1);
            end
          end
        end
        StWWrite: begin
          col_q <= '0;
          for (int c = 0; c < int'(max_cols); c++) row_buf_q[c] <= '0;
          if (last_row) begin
            row_q <= '0;
            if (last_layer) begin
              layer_q <= '0;
              state_q <= StIdle;
            end else begin
              layer_q <= layer_q + LayerW'(1);
              state_q <= StWCollect;
            end
          end else begin
            row_q   <= row_q + RowW'(1);
            state_q <= StWCollect;
          end
        end
        StICollect: begin
          if (accept) begin
            input_values[int'(col_q)*datawidth +: datawidth] <= s_data;
            if (last_input) begin
              en           <= 1'b1;
              input_loaded <= 1'b1;
              state_q      <= StLaunch;
            end else begin
              col_q <= col_q + ColW'(1);
            end
          end
        end
        StLaunch: begin
          wait_q  <= '0;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (core_final_done) begin
            result_onehot <= core_final_out;
            result_valid  <= 1'b1;
            state_q       <= StResult;
          end else if (wait_q == WaitW'(timeout_cycles - 1)) begin
            err     <= 1'b1;
            state_q <= StIdle;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StResult: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ann_stream_loader.sv
// Directed bench for ann_stream_loader with a small behavioural stand-in for the ANN core.
module tb_ann_stream_loader;

  logic        clk = 1'b0;
  logic        rst_overall_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        rst_vals;
  logic        train;
  logic [0:0]  train_layer_select;
  logic [0:0]  row_sel;
  logic [23:0] weight_update;
  logic [31:0] bias_updates;
  logic [23:0] input_values;
  logic        en;
  logic        input_loaded;
  logic        core_final_done;
  logic [1:0]  core_final_out;
  logic [1:0]  result_onehot;
  logic        result_valid;
  logic        result_ready;
  logic        err;

  always #5 clk = ~clk;

  ann_stream_loader dut (
    .clk                (clk),
    .rst_overall_n      (rst_overall_n),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .rst_vals           (rst_vals),
    .train              (train),
    .train_layer_select (train_layer_select),
    .row_sel            (row_sel),
    .weight_update      (weight_update),
    .bias_updates       (bias_updates),
    .input_values       (input_values),
    .en                 (en),
    .input_loaded       (input_loaded),
    .core_final_done    (core_final_done),
    .core_final_out     (core_final_out),
    .result_onehot      (result_onehot),
    .result_valid       (result_valid),
    .result_ready       (result_ready),
    .err                (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Train-pulse, launch and clear-pulse recorder.
  logic [23:0] tr_wu [64];
  logic [1:0]  tr_lr [64];
  int tr_cnt = 0;
  int en_cnt = 0;
  int rv_cnt = 0;

  always @(negedge clk) begin
    if (train) begin
      if (tr_cnt < 64) begin
        tr_wu[tr_cnt] = weight_update;
        tr_lr[tr_cnt] = {train_layer_select, row_sel};
      end
      tr_cnt++;
      check("s_ready_in_write", s_ready, 1'b0);
    end
    if (en || input_loaded) begin
      en_cnt++;
      check("en_with_input_loaded", input_loaded, en);
    end
    if (rst_vals) rv_cnt++;
  end

  // Core stand-in: answers 2'b10 three cycles after en; idle output differs to expose passthrough.
  bit core_on = 1'b1;
  int core_dly = 0;

  always @(negedge clk) begin
    core_final_done = 1'b0;
    core_final_out  = 2'b01;
    if (en && core_on) begin
      core_dly = 3;
    end else if (core_dly > 0) begin
      core_dly--;
      if (core_dly == 0) begin
        core_final_done = 1'b1;
        core_final_out  = 2'b10;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("s_ready_wait_timeout", 1'b0, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_weight_frame(input bit gaps);
    logic [7:0] wf [11] = '{8'h01, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                            8'h04, 8'h08, 8'h0C, 8'h10};
    for (int i = 0; i < 11; i++) send_byte(wf[i], gaps);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_trains(input int base);
    logic [23:0] wu_exp [4] = '{24'h0C0804, 24'h181410, 24'h000804, 24'h00100C};
    logic [1:0]  lr_exp [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    check("train_count", tr_cnt - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("train%0d_weight_update", i), tr_wu[base+i], wu_exp[i]);
      check($sformatf("train%0d_layer_row", i), tr_lr[base+i], lr_exp[i]);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_s_ready"}, s_ready, 1'b1);
    check({pfx, "_train"}, train, 1'b0);
    check({pfx, "_rst_vals"}, rst_vals, 1'b0);
    check({pfx, "_en"}, en, 1'b0);
    check({pfx, "_input_loaded"}, input_loaded, 1'b0);
    check({pfx, "_err"}, err, 1'b0);
    check({pfx, "_result_valid"}, result_valid, 1'b0);
    check({pfx, "_result_onehot"}, result_onehot, 2'b00);
    check({pfx, "_input_values"}, input_values, 24'h0);
    check({pfx, "_weight_update"}, weight_update, 24'h0);
    check({pfx, "_bias_updates"}, bias_updates, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int e0;
    int n;
    rst_overall_n = 1'b0;
    s_valid       = 1'b0;
    s_data        = 8'h00;
    result_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_overall_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Weight frame
    base = tr_cnt;
    send_weight_frame(1'b0);
    check_trains(base);
    check("rst_vals_pulses", rv_cnt, 1);
    check("idle_after_weights", s_ready, 1'b1);

    // Input frame and inference
    send_byte(8'h02, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h0C, 1'b0);
    check("input_values", input_values, 24'h0C0804);
    check("en_after_last_input", en, 1'b1);
    @(negedge clk);
    check("en_single_cycle", en, 1'b0);
    check("en_pulse_count", en_cnt, 1);
    n = 0;
    while (!result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("result_valid", result_valid, 1'b1);
    check("result_onehot", result_onehot, 2'b10);

    // Result held until taken
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_result_valid", result_valid, 1'b1);
      check("hold_result_onehot", result_onehot, 2'b10);
      check("hold_s_ready", s_ready, 1'b0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("taken_result_valid", result_valid, 1'b0);
    check("taken_s_ready", s_ready, 1'b1);

    // Timeout with the core silent
    core_on = 1'b0;
    check("err_before_timeout", err, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    check("input_values_overwrite", input_values, 24'h332211);
    check("en_timeout_frame", en, 1'b1);
    repeat (1023) @(negedge clk);
    check("timeout_still_waiting", s_ready, 1'b0);
    check("timeout_err_not_yet", err, 1'b0);
    @(negedge clk);
    check("timeout_idle", s_ready, 1'b1);
    check("timeout_err", err, 1'b1);
    check("timeout_result_valid", result_valid, 1'b0);
    core_on = 1'b1;

    // Asynchronous reset in the middle of a weight frame
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h0C, 1'b0);
    send_byte(8'h10, 1'b0);
    #1 rst_overall_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_overall_n = 1'b1;
    base = tr_cnt;
    repeat (4) @(negedge clk);
    check("no_train_after_reset", tr_cnt - base, 0);
    send_weight_frame(1'b0);
    check_trains(base);

    // Bad header
    e0   = en_cnt;
    base = tr_cnt;
    send_byte(8'h7F, 1'b0);
    repeat (3) @(negedge clk);
    check("bad_header_err", err, 1'b1);
    check("bad_header_idle", s_ready, 1'b1);
    check("bad_header_no_train", tr_cnt - base, 0);
    check("bad_header_no_en", en_cnt - e0, 0);
    send_weight_frame(1'b0);
    check_trains(base);

    // Random gaps on s_valid
    base = tr_cnt;
    send_weight_frame(1'b1);
    check_trains(base);
    check("err_sticky", err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
